// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one read at a time to instruction
// memory and hands each word to the decoder over valid/ready, with branch redirect and HALT stop.
module fetch_unit #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_pc_i,
  input  logic                  branch_valid_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic [15:0]           mem_data_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [15:0]           instruction_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  halted_o,
  output logic                  busy_o
);

  localparam int DATA_WIDTH = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_HOLD   = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  halted_q, halted_d;

  logic in_fetch, in_hold, accept, is_halt;

  assign in_fetch = (state_q == ST_FETCH);
  assign in_hold  = (state_q == ST_HOLD);
  // A redirect in the same cycle as instr_ready wins, so it is never an accept.
  assign accept   = in_hold && instr_ready_i && !branch_valid_i;
  assign is_halt  = (instr_q[DATA_WIDTH-1:DATA_WIDTH-4] == HALT_OPCODE);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    halted_d   = halted_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start_i) begin
          pc_d     = start_pc_i;
          halted_d = 1'b0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (branch_valid_i) begin
          pc_d    = branch_target_i;
          state_d = ST_FLUSH;
        end else if (mem_ready_i) begin
          instr_d    = mem_data_i;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_ONE;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (branch_valid_i) begin
          pc_d    = branch_target_i;
          state_d = ST_FLUSH;
        end else if (accept) begin
          if (is_halt) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else begin
            state_d  = ST_FETCH;
          end
        end
      end
      ST_FLUSH: state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      halted_q   <= halted_d;
    end
  end

  assign mem_req_o     = in_fetch;
  assign mem_addr_o    = pc_q;
  assign instr_valid_o = in_hold;
  assign instruction_o = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign halted_o      = halted_q;
  assign busy_o        = in_fetch || in_hold || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, handshake latency, backpressure, branch flush, wrap and halt.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_pc;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [7:0]  instr_pc;
  logic        halted;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .start_pc_i     (start_pc),
    .branch_valid_i (branch_valid),
    .branch_target_i(branch_target),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_ready_i    (mem_ready),
    .mem_data_i     (mem_data),
    .instr_valid_o  (instr_valid),
    .instr_ready_i  (instr_ready),
    .instruction_o  (instruction),
    .instr_pc_o     (instr_pc),
    .halted_o       (halted),
    .busy_o         (busy)
  );

  // flags = {mem_req, instr_valid, halted, busy}
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] f;
    #12;
    f = {mem_req, instr_valid, halted, busy};
    total++;
    if (f !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", f); end
    total++;
    if ({mem_addr, instruction, instr_pc} !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", mem_addr, instruction, instr_pc);
    end
    rst_n = 1'b1;
    step();
    branch_valid = 1'b1; branch_target = 8'h55;
    step();
    branch_valid = 1'b0;
    total++;
    if ({busy, mem_addr} !== 9'h000) begin
      bad++; $display("FAIL idle_branch_ignored got busy=%b addr=%h want 0/00", busy, mem_addr);
    end
    // reset asserted mid-FETCH, between clock edges
    start = 1'b1; start_pc = 8'h33;
    step();
    start = 1'b0;
    total++;
    if ({mem_req, busy, mem_addr} !== {2'b11, 8'h33}) begin
      bad++; $display("FAIL pre_reset_fetch got req=%b busy=%b addr=%h want 1/1/33", mem_req, busy, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    f = {mem_req, instr_valid, halted, busy};
    total++;
    if (f !== 4'b0000 || mem_addr !== 8'h00) begin
      bad++; $display("FAIL async_reset got flags=%b addr=%h want 0000/00", f, mem_addr);
    end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    start = 1'b1; start_pc = 8'h10;
    mem_ready = 1'b1; mem_data = 16'h1234; instr_ready = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({mem_req, instr_valid, mem_addr} !== {2'b10, 8'h10}) begin
      bad++; $display("FAIL first_fetch got req=%b vld=%b addr=%h want 1/0/10", mem_req, instr_valid, mem_addr);
    end
    step();
    mem_ready = 1'b0;
    total++;
    if ({instr_valid, mem_req, instruction, instr_pc} !== {2'b10, 16'h1234, 8'h10}) begin
      bad++; $display("FAIL first_instr got vld=%b req=%b ins=%h pc=%h want 1/0/1234/10",
                      instr_valid, mem_req, instruction, instr_pc);
    end
    step();
    total++;
    if ({mem_req, instr_valid, mem_addr} !== {2'b10, 8'h11}) begin
      bad++; $display("FAIL next_fetch got req=%b vld=%b addr=%h want 1/0/11", mem_req, instr_valid, mem_addr);
    end
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b1; mem_data = 16'h5678; instr_ready = 1'b0;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({instr_valid, mem_req, instruction, instr_pc} !== {2'b10, 16'h5678, 8'h11}) begin
        bad++; $display("FAIL backpressure_%0d got vld=%b req=%b ins=%h pc=%h want 1/0/5678/11",
                        i, instr_valid, mem_req, instruction, instr_pc);
      end
      step();
    end
    total++;
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL still_hold got=%b want=1", instr_valid); end
    instr_ready = 1'b1;
    step();
    total++;
    if ({mem_req, instr_valid, mem_addr} !== {2'b10, 8'h12}) begin
      bad++; $display("FAIL bp_accept got req=%b vld=%b addr=%h want 1/0/12", mem_req, instr_valid, mem_addr);
    end
  endtask

  task automatic test_branch_fetch();
    mem_ready = 1'b1; mem_data = 16'hABCD;
    branch_valid = 1'b1; branch_target = 8'h40;
    step();
    mem_ready = 1'b0; branch_valid = 1'b0;
    total++;
    if ({mem_req, instr_valid, busy} !== 3'b001) begin
      bad++; $display("FAIL flush_fetch got req=%b vld=%b busy=%b want 0/0/1", mem_req, instr_valid, busy);
    end
    total++;
    if (instruction !== 16'h5678) begin
      bad++; $display("FAIL discard_data got=%h want=5678", instruction);
    end
    step();
    total++;
    if ({mem_req, instr_valid, mem_addr} !== {2'b10, 8'h40}) begin
      bad++; $display("FAIL after_flush got req=%b vld=%b addr=%h want 1/0/40", mem_req, instr_valid, mem_addr);
    end
  endtask

  task automatic test_branch_hold();
    mem_ready = 1'b1; mem_data = 16'h1111; instr_ready = 1'b0;
    step();
    mem_ready = 1'b0;
    total++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 16'h1111, 8'h40}) begin
      bad++; $display("FAIL hold_40 got vld=%b ins=%h pc=%h want 1/1111/40", instr_valid, instruction, instr_pc);
    end
    instr_ready = 1'b1; branch_valid = 1'b1; branch_target = 8'h80;
    step();
    branch_valid = 1'b0;
    start = 1'b1; start_pc = 8'h99;  // ignored while flushing
    total++;
    if ({mem_req, instr_valid, busy, halted} !== 4'b0010) begin
      bad++; $display("FAIL flush_hold got req=%b vld=%b busy=%b halt=%b want 0/0/1/0",
                      mem_req, instr_valid, busy, halted);
    end
    step();
    start = 1'b0;
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h80}) begin
      bad++; $display("FAIL target_fetch got req=%b addr=%h want 1/80", mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap_halt();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    start = 1'b1; start_pc = 8'hFF; instr_ready = 1'b1;
    step();
    start = 1'b0;
    mem_ready = 1'b1; mem_data = 16'h0123;
    step();
    mem_ready = 1'b0;
    total++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 16'h0123, 8'hFF}) begin
      bad++; $display("FAIL wrap_first got vld=%b ins=%h pc=%h want 1/0123/ff", instr_valid, instruction, instr_pc);
    end
    step();
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL wrap_addr got req=%b addr=%h want 1/00", mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_data = 16'hF000;
    step();
    mem_ready = 1'b0;
    total++;
    if ({instr_valid, instruction, instr_pc, halted} !== {1'b1, 16'hF000, 8'h00, 1'b0}) begin
      bad++; $display("FAIL halt_instr got vld=%b ins=%h pc=%h halt=%b want 1/f000/00/0",
                      instr_valid, instruction, instr_pc, halted);
    end
    step();
    total++;
    if ({mem_req, instr_valid, halted, busy, mem_addr} !== {4'b0010, 8'h01}) begin
      bad++; $display("FAIL halted got req=%b vld=%b halt=%b busy=%b pc=%h want 0/0/1/0/01",
                      mem_req, instr_valid, halted, busy, mem_addr);
    end
    branch_valid = 1'b1; branch_target = 8'h77; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    branch_valid = 1'b0; mem_ready = 1'b0;
    total++;
    if ({mem_req, halted, busy, mem_addr} !== {3'b010, 8'h01}) begin
      bad++; $display("FAIL halt_sticky got req=%b halt=%b busy=%b pc=%h want 0/1/0/01",
                      mem_req, halted, busy, mem_addr);
    end
    start = 1'b1; start_pc = 8'h20;
    step();
    start = 1'b0;
    total++;
    if ({mem_req, halted, busy, mem_addr} !== {3'b101, 8'h20}) begin
      bad++; $display("FAIL restart got req=%b halt=%b busy=%b addr=%h want 1/0/1/20",
                      mem_req, halted, busy, mem_addr);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_pc = '0;
    branch_valid = 1'b0; branch_target = '0;
    mem_ready = 1'b0; mem_data = '0; instr_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_branch_fetch();
    test_branch_hold();
    test_wrap_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
